// File: rtl/dense_layer_stream.sv
// Sequential int8 dense layer: one MAC per cycle, one neuron at a time, requantized
// int8 results streamed out over valid/ready. Define DENSE_RELU_EN to fuse a ReLU into saturation.
module dense_layer_stream #(
  parameter int INPUT_SIZE  = 256,
  parameter int OUTPUT_SIZE = 64,
  parameter int INPUT_ZP    = 0,
  parameter int OUTPUT_ZP   = 0,
  parameter int OUT_MULT    = 1,
  parameter int OUT_SHIFT   = 1,
  localparam int WAW = $clog2(INPUT_SIZE * OUTPUT_SIZE),
  localparam int OAW = $clog2(OUTPUT_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_dense,
  input  logic                  input_valid,
  input  logic signed [7:0]     input_vector [0:INPUT_SIZE-1],
  output logic [WAW-1:0]        weight_addr,
  output logic                  weight_rd_en,
  input  logic signed [7:0]     weight_data,
  output logic [OAW-1:0]        bias_addr,
  input  logic signed [31:0]    bias_data,
  output logic signed [7:0]     out_data,
  output logic [OAW-1:0]        out_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  layer_complete
);

  localparam int KW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam logic [KW-1:0]         K_LAST     = KW'(INPUT_SIZE - 1);
  localparam logic [OAW-1:0]        O_LAST     = OAW'(OUTPUT_SIZE - 1);
  localparam logic [WAW-1:0]        ROW_STRIDE = WAW'(INPUT_SIZE);
  localparam logic signed [8:0]     X_ZP       = 9'(INPUT_ZP);
  localparam logic signed [63:0]    RND        = 64'sd1 <<< (OUT_SHIFT - 1);
  localparam logic signed [63:0]    SAT_HI     = 64'sd127;
`ifdef DENSE_RELU_EN
  localparam logic signed [63:0]    SAT_LO     = 64'(OUTPUT_ZP);
`else
  localparam logic signed [63:0]    SAT_LO     = -64'sd128;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_BIAS, S_MAC, S_REQUANT, S_OUT, S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [KW-1:0]         r_k;
  logic [OAW-1:0]        r_o;
  logic [WAW-1:0]        r_base;
  logic [WAW-1:0]        r_waddr_hold;
  logic signed [7:0]     r_out_data;
  logic [OAW-1:0]        r_out_index;
  logic signed [31:0]    r_acc_p1;
  logic signed [8:0]     w_x_p0;
  logic signed [16:0]    w_prod_p0;
  logic                  w_start;
  logic                  w_last_k;
  logic                  w_rd_en;
  logic [WAW-1:0]        w_waddr;

  function automatic logic signed [63:0] round_shift(input logic signed [31:0] acc);
    logic signed [63:0] prod;
    prod = 64'(acc) * 64'(OUT_MULT);
    return (prod + RND) >>> OUT_SHIFT;
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [63:0] v);
    if (v > SAT_HI)
      return 8'sd127;
    else if (v < SAT_LO)
      return SAT_LO[7:0];
    else
      return v[7:0];
  endfunction

  assign w_start  = start_dense && input_valid;
  assign w_last_k = (r_k == K_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start) w_state_nxt = S_BIAS;
      S_BIAS:         w_state_nxt = S_MAC;
      S_MAC:          if (w_last_k) w_state_nxt = S_REQUANT;
      S_REQUANT:      w_state_nxt = S_OUT;
      S_OUT:          if (out_ready) w_state_nxt = (r_o == O_LAST) ? S_DONE : S_BIAS;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Address is fetched one cycle ahead of its MAC; it holds its last value whenever no read is issued.
  always_comb begin
    w_rd_en = 1'b0;
    w_waddr = r_waddr_hold;
    if (r_state == S_BIAS) begin
      w_rd_en = 1'b1;
      w_waddr = r_base;
    end else if (r_state == S_MAC && !w_last_k) begin
      w_rd_en = 1'b1;
      w_waddr = r_base + WAW'(r_k) + WAW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_o          <= '0;
      r_base       <= '0;
      r_waddr_hold <= '0;
      r_out_data   <= '0;
      r_out_index  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_waddr_hold <= w_waddr;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start) begin
            r_o    <= '0;
            r_base <= '0;
          end
        end
        S_BIAS: r_k <= '0;
        S_MAC: begin
          if (!w_last_k) r_k <= r_k + KW'(1);
        end
        S_REQUANT: begin
          r_out_data  <= sat8(round_shift(r_acc_p1) + 64'(OUTPUT_ZP));
          r_out_index <= r_o;
        end
        S_OUT: begin
          if (out_ready && r_o != O_LAST) begin
            r_o    <= r_o + OAW'(1);
            r_base <= r_base + ROW_STRIDE;
          end
        end
        default: ;
      endcase
    end
  end

  // p0: operand fetch and product; p1: int32 accumulator (wraps)
  assign w_x_p0    = $signed({input_vector[r_k][7], input_vector[r_k]}) - X_ZP;
  assign w_prod_p0 = weight_data * w_x_p0;

  always_ff @(posedge clk) begin
    if (r_state == S_MAC)
      r_acc_p1 <= ((r_k == '0) ? bias_data : r_acc_p1) + $signed({{15{w_prod_p0[16]}}, w_prod_p0});
  end

  assign weight_rd_en   = w_rd_en;
  assign weight_addr    = w_waddr;
  assign bias_addr      = r_o;
  assign out_data       = r_out_data;
  assign out_index      = r_out_index;
  assign out_valid      = (r_state == S_OUT);
  assign busy           = (r_state == S_BIAS) || (r_state == S_MAC) ||
                          (r_state == S_REQUANT) || (r_state == S_OUT);
  assign layer_complete = (r_state == S_DONE);

endmodule

// File: doc/dense_layer_stream.md
# dense_layer_stream

Fully connected (dense) int8 layer that consumes the flattened feature vector produced by the flatten stage and computes one output neuron at a time with a single sequential MAC. Weights and biases come from external synchronous ROMs. Each int32 accumulation is requantized to int8 and streamed out over a valid/ready handshake. The block sits directly downstream of the flatten stage and upstream of the classifier/argmax stage.

## Interface
- INPUT_SIZE, 256: flattened input length (matches flatten OUTPUT_SIZE)
- OUTPUT_SIZE, 64: neuron count
- INPUT_ZP, 0: signed int8 input zero point
- OUTPUT_ZP, 0: signed int8 output zero point
- OUT_MULT, 1: signed 32-bit requant multiplier
- OUT_SHIFT, 1: requant right shift, legal range 1..62

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start_dense  in  1  start request
- input_valid  in  1  input_vector holds a complete vector (flatten output_valid)
- input_vector  in  int8_t[0:INPUT_SIZE-1]  flattened vector; must stay stable while busy
- weight_addr  out  $clog2(INPUT_SIZE*OUTPUT_SIZE)  weight ROM address, row-major [neuron][input]
- weight_rd_en  out  1  weight ROM read enable
- weight_data  in  int8_t  weight ROM data, 1-cycle latency
- bias_addr  out  $clog2(OUTPUT_SIZE)  bias ROM address
- bias_data  in  int32_t  bias ROM data, 1-cycle latency
- out_data  out  int8_t  requantized neuron output
- out_index  out  $clog2(OUTPUT_SIZE)  neuron index of out_data
- out_valid  out  1  out_data/out_index valid
- out_ready  in  1  consumer accepts
- busy  out  1  high from BIAS through OUT
- layer_complete  out  1  level; high in DONE

## Operation
- States: IDLE, BIAS, MAC, REQUANT, OUT, DONE.
- IDLE/DONE -> BIAS when start_dense && input_valid. Clear neuron o=0 and input index k=0. A start with input_valid low is ignored. A start while busy is ignored.
- BIAS (1 cycle): drive bias_addr=o, weight_addr=o*INPUT_SIZE, weight_rd_en=1.
- MAC (INPUT_SIZE cycles, k=0..INPUT_SIZE-1):
  - Compute prod = weight_data * (input_vector[k] - INPUT_ZP), a signed 9-bit operand.
  - k=0: acc <= bias_data + prod. Otherwise acc <= acc + prod.
  - Issue weight_addr = o*INPUT_SIZE+k+1 with weight_rd_en=1, except on the last cycle.
- acc is int32 with two's-complement wrap; no overflow detection.
- REQUANT (1 cycle): r = (acc*OUT_MULT + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, computed at 64 bits with an arithmetic shift. Then r += OUTPUT_ZP, saturated to [-128,127]. The result is registered into out_data, and out_index=o.
- OUT: out_valid=1 until out_ready is sampled high.
  - On that transfer, if o==OUTPUT_SIZE-1 go to DONE; else o++ and go to BIAS.
- DONE: layer_complete=1. The next accepted start restarts at o=0.
- weight_rd_en=0 in all other states. Addresses hold their last value.

## Timing
- Reset values: out_data=0, out_index=0, out_valid=0, busy=0, layer_complete=0, weight_rd_en=0, weight_addr=0, bias_addr=0; state IDLE.
- An asynchronous reset assertion mid-operation forces IDLE immediately and discards partial results. Operation resumes only after a new start following deassertion.
- Start accepted at edge T: BIAS at T+1, MAC T+2..T+1+INPUT_SIZE, REQUANT T+2+INPUT_SIZE, out_valid high from T+3+INPUT_SIZE.
- Each subsequent neuron has the same INPUT_SIZE+2 cycle gap after the previous transfer.
- With out_ready held high, one output occurs every INPUT_SIZE+3 cycles.
- Backpressure: out_data and out_index must stay stable while out_valid && !out_ready. No ROM reads occur while in OUT.
- out_ready high outside OUT has no effect.

## Configuration
- DENSE_RELU_EN defined: the saturation lower bound is OUTPUT_ZP instead of -128 (fused ReLU).
- DENSE_RELU_EN undefined: full [-128,127] saturation, no ReLU.

## Test plan
- Basic: INPUT_SIZE=4, OUTPUT_SIZE=2, OUT_MULT=1, OUT_SHIFT=1, zero points 0, x=[1,2,3,4].
  - Neuron 0: w0=[1,1,1,1], bias 0 -> out 5, index 0.
  - Neuron 1: w1=[-1,-1,-1,-1], bias -2 -> out -6, index 1 (0 with DENSE_RELU_EN).
  - Then layer_complete=1 and busy=0.
- Latency: start accepted at edge T -> out_valid first high at T+7 for INPUT_SIZE=4. Exactly 4 weight reads at addresses 0..3, then BIAS for neuron 1 reads 4..7.
- Saturation: all x=127, all w=127, bias 0 -> out 127. All w=-127 -> out -128 (OUTPUT_ZP with DENSE_RELU_EN).
- Backpressure: out_ready low for 5 cycles during OUT -> out_data and out_index constant, weight_rd_en stays 0, no neuron advance. A single ready cycle moves to the next neuron.
- Start gating:
  - start_dense with input_valid=0 -> stays IDLE.
  - start_dense during MAC -> ignored, results unchanged.
- Reset: assert reset mid-MAC of neuron 1 -> all outputs immediately reach reset values. A new start after deassertion produces out 5 for neuron 0 again.
